// File: rtl/toggle_monitor_asg.sv
`default_nettype none
// ============================================================================
// Module   : toggle_monitor_asg
// Purpose  : Per-net switching-activity monitor. Over a START/STOP window it
//            counts toggles (TC) and cycles-high (T1) per net, plus counted
//            window cycles. Results are read back one net per request in HOLD.
// Revision : 1.0 - initial release
// ============================================================================
module toggle_monitor_asg #(
    parameter int NUM_SIG = 8,
    parameter int CNT_W   = 16,
    parameter int IDX_W   = 3
) (
    input  logic               CP,
    input  logic               RST,
    input  logic               START,
    input  logic               STOP,
    input  logic [NUM_SIG-1:0] SIG,
    input  logic               RD_REQ,
    input  logic [IDX_W-1:0]   RD_IDX,
    output logic               RD_VALID,
    output logic [CNT_W-1:0]   RD_TC,
    output logic [CNT_W-1:0]   RD_T1,
    output logic [CNT_W-1:0]   WIN_CYCLES,
    output logic               BUSY,
    output logic               DONE,
    output logic               OVF
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [CNT_W-1:0]   tc [NUM_SIG];
    logic [CNT_W-1:0]   t1 [NUM_SIG];
    logic [CNT_W-1:0]   win_cnt;
    logic [NUM_SIG-1:0] prev;
    logic               ovf;

    logic               arm;
    logic               count_en;
    logic               win_last;
    logic               win_blk;
    logic [NUM_SIG-1:0] tc_inc;
    logic [NUM_SIG-1:0] t1_inc;
    logic [NUM_SIG-1:0] tc_blk;
    logic [NUM_SIG-1:0] t1_blk;
    logic               ovf_set;
    logic               rd_accept;
    logic [CNT_W-1:0]   rd_tc_sel;
    logic [CNT_W-1:0]   rd_t1_sel;

    // START re-arms from IDLE or HOLD only; it wins over STOP and RD_REQ.
    assign arm       = (state != S_MEASURE) && START;
    // A MEASURE cycle is counted unless STOP is present in that cycle.
    assign count_en  = (state == S_MEASURE) && !STOP;
    // The window counter can only ever sit at its maximum outside MEASURE,
    // so reaching max-1 on a counted cycle is what ends the window.
    assign win_last  = count_en && (win_cnt == CNT_MAX - 1'b1);
    assign win_blk   = count_en && (win_cnt == CNT_MAX);
    assign rd_accept = (state == S_HOLD) && RD_REQ && !START;

    // Per-net increment requests and saturation-blocked increments.
    always_comb begin
        tc_inc = '0;
        t1_inc = '0;
        tc_blk = '0;
        t1_blk = '0;
        for (int i = 0; i < NUM_SIG; i++) begin
            tc_inc[i] = count_en && (SIG[i] != prev[i]);
            t1_inc[i] = count_en && SIG[i];
            tc_blk[i] = tc_inc[i] && (tc[i] == CNT_MAX);
            t1_blk[i] = t1_inc[i] && (t1[i] == CNT_MAX);
        end
    end

    assign ovf_set = (|tc_blk) || (|t1_blk) || win_blk || win_last;

    // State register.
    always_ff @(posedge CP or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (START) state_nxt = S_MEASURE;
            S_MEASURE: if (STOP || win_last) state_nxt = S_HOLD;
            S_HOLD:    if (START) state_nxt = S_MEASURE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Per-net toggle and cycles-high counters, saturating.
    always_ff @(posedge CP or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_SIG; i++) begin
                tc[i] <= '0;
                t1[i] <= '0;
            end
        end else if (arm) begin
            for (int i = 0; i < NUM_SIG; i++) begin
                tc[i] <= '0;
                t1[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SIG; i++) begin
                if (tc_inc[i] && !tc_blk[i]) tc[i] <= tc[i] + 1'b1;
                if (t1_inc[i] && !t1_blk[i]) t1[i] <= t1[i] + 1'b1;
            end
        end
    end

    // Window counter, previous sample and sticky overflow flag.
    always_ff @(posedge CP or posedge RST) begin
        if (RST) begin
            win_cnt <= '0;
            prev    <= '0;
            ovf     <= 1'b0;
        end else if (arm) begin
            win_cnt <= '0;
            prev    <= SIG;
            ovf     <= 1'b0;
        end else begin
            if (count_en) begin
                prev <= SIG;
                if (!win_blk) win_cnt <= win_cnt + 1'b1;
            end
            if (ovf_set) ovf <= 1'b1;
        end
    end

    // Read mux; indices with no net behind them return zero.
    always_comb begin
        rd_tc_sel = '0;
        rd_t1_sel = '0;
        for (int i = 0; i < NUM_SIG; i++) begin
            if (int'(RD_IDX) == i) begin
                rd_tc_sel = tc[i];
                rd_t1_sel = t1[i];
            end
        end
    end

    // Read port: one-cycle valid pulse, data held until the next accepted read.
    always_ff @(posedge CP or posedge RST) begin
        if (RST) begin
            RD_VALID <= 1'b0;
            RD_TC    <= '0;
            RD_T1    <= '0;
        end else begin
            RD_VALID <= rd_accept;
            if (rd_accept) begin
                RD_TC <= rd_tc_sel;
                RD_T1 <= rd_t1_sel;
            end
        end
    end

    assign WIN_CYCLES = win_cnt;
    assign BUSY       = (state == S_MEASURE);
    assign DONE       = (state == S_HOLD);
    assign OVF        = ovf;

endmodule
`default_nettype wire

// File: doc/toggle_monitor_asg.md
Name: toggle_monitor_asg

Overview:
Switching-activity monitor for gate-level power work on designs built from the asg cell library. It samples NUM_SIG nets every clock over a START/STOP measurement window. Per net it accumulates a toggle count (TC) and a cycles-high count (T1), which correspond to SAIF TC/T1. The accumulated window is then read back one net at a time over a request/valid port, so the bench or a power-estimation harness can compare RTL activity against annotated SAIF activity.

Parameters:
NUM_SIG, 8, number of monitored nets
CNT_W, 16, width of every counter (TC, T1, window)
IDX_W, 3, read-index width; must satisfy 2**IDX_W >= NUM_SIG

Ports:
CP  input  1  clock, rising edge
RST  input  1  asynchronous reset, active-high
START  input  1  arm and clear counters; begin a window
STOP  input  1  end the window
SIG  input  NUM_SIG  monitored nets, synchronous to CP
RD_REQ  input  1  read request, accepted only in HOLD
RD_IDX  input  IDX_W  net index for the read
RD_VALID  output  1  read data valid, 1-cycle pulse
RD_TC  output  CNT_W  toggle count of the indexed net
RD_T1  output  CNT_W  cycles-high count of the indexed net
WIN_CYCLES  output  CNT_W  number of counted window cycles
BUSY  output  1  high in MEASURE
DONE  output  1  high in HOLD
OVF  output  1  sticky; set when any counter saturates during the window

Behaviour:
- Reset, asynchronous and active-high: state goes to IDLE. All counters, the previous-sample register, RD_VALID, RD_TC, RD_T1, WIN_CYCLES, BUSY, DONE and OVF go to 0.
- States are IDLE, MEASURE and HOLD.
- IDLE or HOLD with START=1:
  - clear all TC, T1 and window counters and OVF;
  - load prev <= SIG;
  - next state is MEASURE.
  - START has priority over STOP and RD_REQ in the same cycle.
- MEASURE with STOP=0, for each i:
  - if SIG[i] != prev[i], increment TC[i];
  - if SIG[i] == 1, increment T1[i];
  - prev <= SIG;
  - increment the window counter.
- MEASURE with STOP=1: the cycle is not counted; next state is HOLD.
- START while in MEASURE is ignored.
- Saturation: every counter saturates at 2**CNT_W-1 and never wraps. Any increment that is blocked by saturation sets OVF.
- When the window counter reaches 2**CNT_W-1 in MEASURE, the next state is HOLD automatically and OVF=1.
- BUSY = (state==MEASURE). DONE = (state==HOLD). Both are registered state decodes, with no extra latency.
- WIN_CYCLES continuously reflects the window counter.
- Readout:
  - An RD_REQ sampled in HOLD gives RD_VALID=1 on the following cycle for exactly 1 cycle.
  - RD_TC and RD_T1 are registered with that same read and hold their value until the next accepted read.
  - Back-to-back requests give back-to-back valid data.
  - If RD_IDX >= NUM_SIG, the read is still valid and returns RD_TC=RD_T1=0.
  - An RD_REQ outside HOLD is ignored: no RD_VALID and no data change.
- Counters hold their values in HOLD and IDLE. Only START or RST clears them.
- RST asserted mid-window or mid-read aborts immediately. There is no RD_VALID after reset deassertion.

Test Plan:
1. Basic window, NUM_SIG=8, CNT_W=16:
   - Stimulus: SIG=0 at START; then SIG[0] alternates 1,0,1,... for 10 cycles, SIG[1]=1 and SIG[2]=0 throughout; then STOP.
   - Required: WIN_CYCLES=10, DONE=1. Reads give idx0 TC=10/T1=5, idx1 TC=1/T1=10, idx2 TC=0/T1=0.
2. Readout handshake in HOLD:
   - Stimulus: RD_REQ with idx 0,1,2 on consecutive cycles.
   - Required: RD_VALID high for 3 consecutive cycles, each starting one cycle after its request, with the matching data.
   - Stimulus: RD_IDX=7 with NUM_SIG=6.
   - Required: RD_VALID=1 with zeros.
3. Saturation with CNT_W=4:
   - Stimulus: START, then SIG[0] toggles every cycle with no STOP.
   - Required: after 15 counted cycles, DONE=1, OVF=1, WIN_CYCLES=15, idx0 TC=15.
4. Ignored inputs during MEASURE:
   - Stimulus: RD_REQ in MEASURE.
   - Required: no RD_VALID.
   - Stimulus: START in MEASURE.
   - Required: counters are not cleared.
   - Stimulus: START and STOP in the same cycle in IDLE.
   - Required: MEASURE entered.
5. Re-arm and reset:
   - Stimulus: START in HOLD.
   - Required: counters and OVF cleared; MEASURE next cycle.
   - Stimulus: RST pulsed mid-MEASURE.
   - Required: immediately IDLE with all outputs 0; a subsequent START works normally.
